// File: rtl/div_bus_adapter.sv
// rtl/div_bus_adapter.sv - byte-serial host adapter for the 16-bit restoring divider (optional macro: DIVBUS_ZERO_SHORTCUT_EN)
module div_bus_adapter (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  data_out,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        div_start,
    output logic [15:0] div_A,
    output logic [15:0] div_B,
    input  logic [15:0] div_Quotient,
    input  logic [15:0] div_Remainder,
    input  logic        div_ready,
    input  logic        div_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_RX,
        S_START,
        S_GUARD,
        S_WAIT,
        S_TX
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] rem_q, rem_d;
    logic        err_q, err_d;
    logic [2:0]  tx_last;

    // Error responses are a single status byte; normal results are five bytes.
    assign tx_last = err_q ? 3'd0 : 3'd4;

    // State and datapath registers; reset discards any partial operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RX;
            rx_cnt_q <= 2'd0;
            tx_cnt_q <= 3'd0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            quo_q    <= 16'h0000;
            rem_q    <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: assemble operands, run the divider handshake, stream the reply.
    always_comb begin
        state_d  = state_q;
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        err_d    = err_q;
        case (state_q)
            S_RX: begin
                if (in_valid) begin
                    rx_cnt_d = rx_cnt_q + 2'd1;
                    case (rx_cnt_q)
                        2'd0:    a_d[7:0]  = data_in;
                        2'd1:    a_d[15:8] = data_in;
                        2'd2:    b_d[7:0]  = data_in;
                        default: b_d[15:8] = data_in;
                    endcase
                    if (rx_cnt_q == 2'd3) begin
                        tx_cnt_d = 3'd0;
`ifdef DIVBUS_ZERO_SHORTCUT_EN
                        if ({data_in, b_q[7:0]} == 16'h0000) begin
                            err_d   = 1'b1;
                            state_d = S_TX;
                        end else begin
                            state_d = S_START;
                        end
`else
                        state_d = S_START;
`endif
                    end
                end
            end
            S_START: state_d = S_GUARD;
            // The divider may still be showing ready from the previous operation here.
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (div_error) begin
                    err_d    = 1'b1;
                    tx_cnt_d = 3'd0;
                    state_d  = S_TX;
                end else if (div_ready) begin
                    err_d    = 1'b0;
                    quo_d    = div_Quotient;
                    rem_d    = div_Remainder;
                    tx_cnt_d = 3'd0;
                    state_d  = S_TX;
                end
            end
            S_TX: begin
                if (out_ack) begin
                    if (tx_cnt_q == tx_last) begin
                        tx_cnt_d = 3'd0;
                        state_d  = S_RX;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_RX;
        endcase
    end

    // Outputs decoded from state; the outbound byte follows tx_cnt so an ack advances it at the same edge.
    always_comb begin
        data_out = 8'h00;
        if (state_q == S_TX) begin
            case (tx_cnt_q)
                3'd0:    data_out = {7'd0, err_q};
                3'd1:    data_out = quo_q[7:0];
                3'd2:    data_out = quo_q[15:8];
                3'd3:    data_out = rem_q[7:0];
                default: data_out = rem_q[15:8];
            endcase
        end
    end

    assign in_ready  = (state_q == S_RX);
    assign busy      = (state_q != S_RX);
    assign out_valid = (state_q == S_TX);
    assign div_start = (state_q == S_START);
    assign div_A     = a_q;
    assign div_B     = b_q;

endmodule

// File: tb/tb_div_bus_adapter.sv
// tb/tb_div_bus_adapter.sv - self-checking bench for div_bus_adapter
module tb_div_bus_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        out_ack;
    logic        div_start;
    logic [15:0] div_A;
    logic [15:0] div_B;
    logic [15:0] div_Quotient;
    logic [15:0] div_Remainder;
    logic        div_ready;
    logic        div_error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    bit div_hold = 1'b0;

    div_bus_adapter dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ack(out_ack),
        .div_start(div_start), .div_A(div_A), .div_B(div_B),
        .div_Quotient(div_Quotient), .div_Remainder(div_Remainder),
        .div_ready(div_ready), .div_error(div_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Divider stand-in: drops ready one cycle after start, answers after a random latency, holds the level.
    initial begin
        bit pend;
        int lat;
        pend = 1'b0;
        lat = -1;
        div_ready = 1'b0;
        div_error = 1'b0;
        div_Quotient = 16'h0;
        div_Remainder = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                lat = -1;
            end else if (div_start) begin
                starts++;
                pend = 1'b1;
            end else if (pend) begin
                pend = 1'b0;
                div_ready = 1'b0;
                div_error = 1'b0;
                lat = $urandom_range(0, 5);
            end else if (lat > 0) begin
                lat--;
            end else if (lat == 0 && !div_hold) begin
                if (div_B == 16'h0) begin
                    div_error = 1'b1;
                end else begin
                    div_Quotient = div_A / div_B;
                    div_Remainder = div_A % div_B;
                    div_ready = 1'b1;
                end
                lat = -1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        data_in = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, out_valid, 1);
    endtask

    // hold < 0: stream the whole reply with out_ack held high; otherwise stall each byte for hold cycles.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold, input bit junk);
        int s0;
        bit shortcut;
        logic [15:0] q;
        logic [15:0] r;
        logic [7:0] exp_q[$];
        s0 = starts;
`ifdef DIVBUS_ZERO_SHORTCUT_EN
        shortcut = (b == 16'h0);
`else
        shortcut = 1'b0;
`endif
        if (b == 16'h0) begin
            exp_q = '{8'h01};
        end else begin
            q = a / b;
            r = a % b;
            exp_q = '{8'h00, q[7:0], q[15:8], r[7:0], r[15:8]};
        end
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
        @(negedge clk);
        if (shortcut) begin
            check("shortcut_valid", out_valid, 1);
            check("shortcut_byte", data_out, 8'h01);
            check("shortcut_nostart", div_start, 0);
        end else begin
            check("start_pulse", div_start, 1);
            check("start_busy", busy, 1);
            check("start_in_ready", in_ready, 0);
            check("start_no_valid", out_valid, 0);
            @(negedge clk);
            check("guard_start_low", div_start, 0);
            check("guard_no_valid", out_valid, 0);
        end
        check("op_div_A", div_A, a);
        check("op_div_B", div_B, b);
        if (junk) begin
            data_in = 8'($urandom);
            in_valid = 1'b1;
        end
        if (hold < 0) begin
            wait_out_valid("burst_valid");
            in_valid = 1'b0;
            out_ack = 1'b1;
            foreach (exp_q[i]) begin
                check("burst_valid_hi", out_valid, 1);
                check("burst_byte", data_out, exp_q[i]);
                @(negedge clk);
            end
            out_ack = 1'b0;
        end else begin
            foreach (exp_q[i]) begin
                wait_out_valid("rx_valid");
                for (int k = 0; k < hold; k++) begin
                    check("stall_byte", data_out, exp_q[i]);
                    check("stall_valid", out_valid, 1);
                    check("stall_in_ready", in_ready, 0);
                    @(negedge clk);
                end
                check("out_byte", data_out, exp_q[i]);
                check("hold_div_A", div_A, a);
                check("hold_div_B", div_B, b);
                in_valid = 1'b0;
                out_ack = 1'b1;
                @(posedge clk);
                #1;
                out_ack = 1'b0;
            end
            @(negedge clk);
        end
        check("done_valid_low", out_valid, 0);
        check("done_in_ready", in_ready, 1);
        check("done_busy", busy, 0);
        check("done_start_count", starts - s0, shortcut ? 0 : 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_data_out"}, data_out, 8'h00);
        check({tag, "_div_start"}, div_start, 0);
        check({tag, "_div_A"}, div_A, 16'h0);
        check({tag, "_div_B"}, div_B, 16'h0);
    endtask

    initial begin
        int s0;
        logic [15:0] ra;
        logic [15:0] rb;
        rst = 1'b1;
        data_in = 8'h00;
        in_valid = 1'b0;
        out_ack = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the operation description.
        run_op(16'd20, 16'd4, -1, 1'b0);
        run_op(16'h002D, 16'h0007, 0, 1'b1);
        run_op(16'h0001, 16'h0000, 0, 1'b0);
        run_op(16'hFFFF, 16'h0003, 5, 1'b0);

        // Reset while the divider is still working.
        div_hold = 1'b1;
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h11);
        send_byte(8'h00);
        repeat (5) @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_no_valid", out_valid, 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        div_hold = 1'b0;

        // Reset after a partial operand.
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_partial");
        @(negedge clk);
        rst = 1'b0;
        s0 = starts;
        repeat (6) @(negedge clk);
        check("no_start_after_rst", starts - s0, 0);
        check("idle_after_rst", busy, 0);
        run_op(16'h0100, 16'h0010, 1, 1'b0);

        // Randomized operands, including zero divisors and occasional stalls.
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(1, 20));
                default: rb = 16'($urandom);
            endcase
            run_op(ra, rb, ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_bus_adapter.md
# div_bus_adapter

Byte-serial host adapter for the 16-bit restoring divider. It is the requester side of the divider's start/ready/error handshake. It assembles A and B from four bytes received on an 8-bit input bus and pulses the divider's start. It then waits for completion and returns a status byte followed by the quotient and remainder over an 8-bit output bus with valid/ack flow control. It sits between the 8-bit system bus and the divider Top_Level.

## Interface
- No parameters; all widths fixed: 8-bit bus, 16-bit operands.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- data_in  in  8  inbound byte
- in_valid  in  1  data_in valid
- in_ready  out  1  adapter accepts a byte; transfer when in_valid && in_ready at a rising edge
- data_out  out  8  outbound byte
- out_valid  out  1  data_out valid; held with stable data until acked
- out_ack  in  1  consumer takes data_out at rising edge when out_valid high
- div_start  out  1  one-cycle start pulse to divider
- div_A  out  16  dividend, registered
- div_B  out  16  divisor, registered
- div_Quotient  in  16  divider quotient
- div_Remainder  in  16  divider remainder
- div_ready  in  1  divider done (level)
- div_error  in  1  divider divide-by-zero flag (level)
- busy  out  1  high in every state except RX

## Operation
- States: RX, START, GUARD, WAIT, TX.
- RX:
  - in_ready=1.
  - Byte counter rx_cnt (0..3) loads A[7:0], A[15:8], B[7:0], B[15:8] in that order.
  - When the 4th byte is accepted, go to START; rx_cnt returns to 0.
- START: div_start=1 for exactly this cycle -> GUARD.
- GUARD: one cycle, ignores div_ready/div_error; covers the divider dropping a stale ready -> WAIT.
- WAIT:
  - div_error=1 -> TX with status 0x01, result length 1 byte. Error has priority over ready.
  - Otherwise div_ready=1 -> capture Quotient and Remainder into a result register -> TX with status 0x00, length 5.
- TX:
  - Byte sequence: status, Q[7:0], Q[15:8], R[7:0], R[15:8]. Error case sends the status byte only.
  - tx_cnt tracks position. On each ack, the next byte appears on data_out at the same edge and out_valid stays high.
  - After the last byte is acked: out_valid=0 -> RX.
- div_A and div_B change only when a byte is accepted. They stay stable from START until the next RX.
- No input bytes are accepted outside RX. in_valid there is ignored, not buffered.
- out_ack while out_valid=0 is ignored.

## Timing
- Reset values:
  - state=RX, in_ready=1, busy=0.
  - out_valid=0, data_out=0x00, div_start=0.
  - div_A=0, div_B=0, all counters and result registers 0.
- Reset asserted mid-operation aborts immediately. Any partial operands or results are discarded, and no div_start is issued after reset.
- Last input byte accepted at edge N:
  - div_start high in cycle N..N+1.
  - GUARD in cycle N+1..N+2.
  - WAIT from edge N+2.
- div_ready or div_error sampled high at edge M in WAIT: out_valid=1 with the status byte from M.
- Minimum output phase: 5 cycles with out_ack held high. Minimum turnaround from the last input byte to the first output byte is 3 cycles plus divider latency.
- No timeout: WAIT holds indefinitely until div_ready or div_error.

## Configuration
- DIVBUS_ZERO_SHORTCUT_EN defined:
  - If the assembled B==0x0000 at the 4th byte, go directly RX->TX with status 0x01 and length 1.
  - div_start is never pulsed. out_valid rises one edge after the last byte.
- Not defined: B=0 goes through START/GUARD/WAIT like any operand. The error is reported only via div_error.

## Test plan
- Bytes 14,00,04,00 (20/4) -> one div_start pulse; output 00,05,00,00,00.
- Bytes 2D,00,07,00 (45/7) -> output 00,06,00,03,00; div_A=0x002D, div_B=0x0007 stable through WAIT.
- Bytes 01,00,00,00 (1/0):
  - Macro off: div_start pulses, divider raises error -> single byte 01.
  - Macro on: no div_start, byte 01 one edge after the last input.
- FF,FF,03,00 with out_ack held low 5 cycles on each byte:
  - data_out and out_valid stay stable while unacked.
  - Sequence is 00,55,55,00,00; in_ready stays 0 until the final ack.
- rst pulsed in WAIT and again after 2 input bytes:
  - All outputs return to reset values; in_ready=1.
  - The next 4 bytes form a clean new operation with no leftover bytes.
